led_matrix: RTL and testbench

Dual-colour 8×8 LED matrix driver and alarm beeper for the water-level detector. Converts the 3-bit level/status code from the level FSM into a row-scanned bar graph. Code 7 is the alarm: the whole matrix flashes red and the beeper sounds. A push button (btn7) toggles beeper mute. Sits between the level-classification FSM and the board's matrix and buzzer pins.

---
 rtl/led_matrix_pkg.sv | 13 +
 rtl/led_matrix_if.sv | 11 +
 rtl/led_matrix_btn_edge.sv | 17 +
 rtl/led_matrix.sv | 89 ++++++++
 tb/tb_led_matrix.sv | 103 ++++++++++
 5 files changed

// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: state codes, display constants and the level colour map
// shared by the LED matrix driver.
package led_matrix_pkg;
   localparam logic [2:0] ST_ALARM   = 3'd7;
   localparam logic [2:0] ST_RED_MIN = 3'd6;
   localparam logic [2:0] ST_YEL_MIN = 3'd4;
   localparam logic [7:0] ROW_OFF    = 8'hFF;
   localparam logic [7:0] COLS_ON    = 8'hFF;
   typedef enum logic [1:0] {OFF, GREEN, YELLOW, RED} colour_e;
   function automatic colour_e level_colour(input logic [2:0] s);
      return s >= ST_RED_MIN ? RED : s >= ST_YEL_MIN ? YELLOW : GREEN;
   endfunction
endpackage

// File: rtl/led_matrix_if.sv
// led_matrix_if: level code and mute button in, matrix and buzzer pins out.
interface led_matrix_if;
   logic [2:0] state;
   logic       btn7;
   logic [7:0] red_led;
   logic [7:0] green_led;
   logic [7:0] row;
   logic       beeper;
   modport master (output state, btn7, input red_led, green_led, row, beeper);
   modport slave  (input state, btn7, output red_led, green_led, row, beeper);
endinterface

// File: rtl/led_matrix_btn_edge.sv
// btn_edge: 2-flop synchroniser plus rising-edge pulse for the mute button.
// Only built when LED_MATRIX_BEEPER_EN is defined.
`ifdef LED_MATRIX_BEEPER_EN
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic rise_o
);
   logic [2:0] sync_q;
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[1:0], btn_i};
   end
   assign rise_o = sync_q[1] & ~sync_q[2];
endmodule
`endif

// File: rtl/led_matrix.sv
// led_matrix: row-scanned bar graph of the water level with a blinking red alarm.
// LED_MATRIX_BEEPER_EN adds the alarm beeper and its btn7 mute toggle.
module led_matrix
   import led_matrix_pkg::*;
#(
   parameter int SCAN_DIV  = 1,
   parameter int BLINK_DIV = 50,
   parameter int BEEP_DIV  = 2
) (
   input logic           clk,
   input logic           rst,
   led_matrix_if.slave   bus
);
   localparam int SW = SCAN_DIV  > 1 ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          phase_q, phase_d;
   logic [7:0]    row_q, row_d, red_q, red_d, green_q, green_d;
   logic          alarm, scan_wrap, blink_wrap;
   colour_e       colour;
   always_comb begin
      alarm       = bus.state == ST_ALARM;
      scan_wrap   = scan_cnt_q == SW'(SCAN_DIV - 1);
      scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
      idx_d       = scan_wrap ? idx_q + 3'd1 : idx_q;
      blink_wrap  = blink_cnt_q == BW'(BLINK_DIV - 1);
      blink_cnt_d = !alarm || blink_wrap ? '0 : blink_cnt_q + 1'b1;
      phase_d     = !alarm || (phase_q ^ blink_wrap);
      // row r is lit when r >= 7 - state, i.e. r + state >= 7
      colour      = alarm ? (phase_q ? RED : OFF)
                  : ({1'b0, idx_q} + {1'b0, bus.state} >= 4'd7) ? level_colour(bus.state) : OFF;
      red_d       = colour == RED   || colour == YELLOW ? COLS_ON : '0;
      green_d     = colour == GREEN || colour == YELLOW ? COLS_ON : '0;
      row_d       = ~(8'd1 << idx_q);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q  <= '0;
         blink_cnt_q <= '0;
         idx_q       <= '0;
         phase_q     <= 1'b1;
         row_q       <= ROW_OFF;
         red_q       <= '0;
         green_q     <= '0;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         idx_q       <= idx_d;
         phase_q     <= phase_d;
         row_q       <= row_d;
         red_q       <= red_d;
         green_q     <= green_d;
      end
   end
   assign bus.row       = row_q;
   assign bus.red_led   = red_q;
   assign bus.green_led = green_q;
`ifdef LED_MATRIX_BEEPER_EN
   localparam int PW = BEEP_DIV > 1 ? $clog2(BEEP_DIV) : 1;
   logic [PW-1:0] beep_cnt_q, beep_cnt_d;
   logic          beep_q, beep_d, mute_q, mute_d, btn_rise, beep_run, beep_wrap;
   btn_edge u_btn (.clk(clk), .rst(rst), .btn_i(bus.btn7), .rise_o(btn_rise));
   always_comb begin
      beep_run   = alarm && !mute_q;
      beep_wrap  = beep_cnt_q == PW'(BEEP_DIV - 1);
      beep_cnt_d = !beep_run || beep_wrap ? '0 : beep_cnt_q + 1'b1;
      beep_d     = beep_run && (beep_q ^ beep_wrap);
      mute_d     = alarm && (mute_q ^ btn_rise);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         beep_cnt_q <= '0;
         beep_q     <= 1'b0;
         mute_q     <= 1'b0;
      end else begin
         beep_cnt_q <= beep_cnt_d;
         beep_q     <= beep_d;
         mute_q     <= mute_d;
      end
   end
   assign bus.beeper = beep_q;
`else
   logic unused_btn;
   assign unused_btn = bus.btn7;
   assign bus.beeper = 1'b0;
`endif
endmodule

// File: tb/tb_led_matrix.sv
// tb_led_matrix: scoreboard bench; expectations are queued as stimulus is driven
// and compared one cycle later against the registered outputs.
module tb_led_matrix;
   localparam int BLINK = 50;
   localparam int BEEP  = 2;
   typedef struct packed {
      logic [7:0] row;
      logic [7:0] red;
      logic [7:0] green;
      logic       beep;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   logic [2:0] m_idx;
   int         m_bc, m_pc;
   logic       m_ph, m_bp, m_mute, s1, s2, s3;
   always #5 clk = ~clk;
   led_matrix_if bus ();
   led_matrix dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
      end
   endtask
   task automatic step(input logic [2:0] st, input logic b, input logic r);
      exp_t e;
      logic pulse, lit;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("row", bus.row, e.row);
         check("red", bus.red_led, e.red);
         check("green", bus.green_led, e.green);
         check("beeper", {7'd0, bus.beeper}, {7'd0, e.beep});
      end
      rst = r;
      bus.state = st;
      bus.btn7 = b;
      if (r) begin
         e = '{row: 8'hFF, red: 8'h00, green: 8'h00, beep: 1'b0};
         m_idx = 0; m_bc = 0; m_pc = 0; m_ph = 1; m_bp = 0; m_mute = 0;
         s1 = 0; s2 = 0; s3 = 0;
      end else begin
         e.row = ~(8'd1 << m_idx);
         lit = m_idx >= 3'd7 - st;
         if (st == 3'd7) begin
            e.red = m_ph ? 8'hFF : 8'h00;
            e.green = 8'h00;
         end else begin
            e.red = (lit && st >= 3'd4) ? 8'hFF : 8'h00;
            e.green = (lit && st <= 3'd5) ? 8'hFF : 8'h00;
         end
         pulse = s2 & ~s3;
         if (st == 3'd7 && !m_mute) begin
            if (m_pc == BEEP - 1) begin m_pc = 0; m_bp = ~m_bp; end
            else m_pc++;
         end else begin
            m_pc = 0; m_bp = 0;
         end
         m_mute = (st == 3'd7) && (m_mute ^ pulse);
         s3 = s2; s2 = s1; s1 = b;
         if (st == 3'd7) begin
            if (m_bc == BLINK - 1) begin m_bc = 0; m_ph = ~m_ph; end
            else m_bc++;
         end else begin
            m_bc = 0; m_ph = 1;
         end
         m_idx = m_idx + 3'd1;
`ifdef LED_MATRIX_BEEPER_EN
         e.beep = m_bp;
`else
         e.beep = 1'b0;
`endif
      end
      sb.push_back(e);
   endtask
   initial begin
      bus.state = 3'd0;
      bus.btn7 = 1'b0;
      repeat (3) step(3'd0, 1'b0, 1'b1);
      repeat (20) step(3'd0, 1'b0, 1'b0);
      repeat (16) step(3'd3, 1'b0, 1'b0);
      repeat (16) step(3'd5, 1'b0, 1'b0);
      repeat (16) step(3'd6, 1'b0, 1'b0);
      repeat (110) step(3'd7, 1'b0, 1'b0);
      for (int p = 0; p < 3; p++) begin
         repeat (p == 2 ? 6 : 2) step(3'd7, 1'b1, 1'b0);
         repeat (20) step(3'd7, 1'b0, 1'b0);
      end
      repeat (5) step(3'd2, 1'b0, 1'b0);
      repeat (20) step(3'd7, 1'b0, 1'b0);
      repeat (2) step(3'd7, 1'b0, 1'b1);
      repeat (10) step(3'd4, 1'b0, 1'b0);
      step(3'd1, 1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
